// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
package bcd_pkg;

   localparam int DIGIT_W = 4;

   typedef logic [DIGIT_W-1:0] bcd_digit_t;

   typedef enum logic {
      IDLE,
      SHIFT
   } state_t;

   function automatic longint unsigned pow10(input int n);
      longint unsigned p;
      p = 64'd1;
      for (int i = 0; i < n; i++) p = p * 64'd10;
      return p;
   endfunction

   function automatic bcd_digit_t add3_adj(input bcd_digit_t digit);
      return (digit >= 4'd5) ? digit + 4'd3 : digit;
   endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit of the double-dabble datapath: adjust by +3, then shift left one bit.
module bcd_digit_cell
   import bcd_pkg::*;
(
   input  bcd_digit_t digit_i,
   input  logic       carry_i,
   output bcd_digit_t digit_o,
   output logic       carry_o
);

   bcd_digit_t adj;

   assign adj     = add3_adj(digit_i);
   assign digit_o = {adj[DIGIT_W-2:0], carry_i};
   assign carry_o = adj[DIGIT_W-1];

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one input bit per clock (double dabble).
// Optional range clamp enabled by defining BCD_RANGE_CHECK_EN.
module bin2bcd_seq
   import bcd_pkg::*;
#(
   parameter int BIN_W   = 6,
   parameter int DIGITS  = 2,
   parameter int MAX_VAL = 60
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic [BIN_W-1:0]          bin,
   output logic                      busy,
   output logic                      valid,
   output logic [DIGIT_W*DIGITS-1:0] bcd,
   output logic                      ovf,
   output logic                      range_err
);

   localparam int CNT_W = $clog2(BIN_W + 1);
   localparam int BCD_W = DIGIT_W * DIGITS;
   localparam longint unsigned OVF_LIM = pow10(DIGITS);

   state_t             state_q, state_d;
   logic [BIN_W-1:0]   shift_q, shift_d;
   logic [BCD_W-1:0]   work_q, work_d, work_nxt;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               busy_q, busy_d;
   logic               valid_q, valid_d;
   logic [BCD_W-1:0]   bcd_q, bcd_d;
   logic               ovf_q, ovf_d;
   logic               ovf_pend_q, ovf_pend_d;
   logic [DIGITS:0]    carry;
`ifdef BCD_RANGE_CHECK_EN
   logic               range_err_q, range_err_d;
   logic               range_pend_q, range_pend_d;
`endif

   assign carry[0] = shift_q[BIN_W-1];

   for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      bcd_digit_cell u_cell (
         .digit_i (work_q[i*DIGIT_W +: DIGIT_W]),
         .carry_i (carry[i]),
         .digit_o (work_nxt[i*DIGIT_W +: DIGIT_W]),
         .carry_o (carry[i+1])
      );
   end

   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
      state_d    = state_q;
      shift_d    = shift_q;
      work_d     = work_q;
      cnt_d      = cnt_q;
      busy_d     = busy_q;
      valid_d    = 1'b0;
      bcd_d      = bcd_q;
      ovf_d      = ovf_q;
      ovf_pend_d = ovf_pend_q;
`ifdef BCD_RANGE_CHECK_EN
      range_err_d  = range_err_q;
      range_pend_d = range_pend_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               shift_d    = bin;
               work_d     = '0;
               cnt_d      = '0;
               busy_d     = 1'b1;
               ovf_pend_d = 64'(bin) >= OVF_LIM;
`ifdef BCD_RANGE_CHECK_EN
               range_pend_d = 64'(bin) > 64'(MAX_VAL);
`endif
               state_d    = SHIFT;
            end
         end
         SHIFT: begin
            // The bit leaving the top digit is parked in the spent low end of the shift register.
            shift_d = BIN_W'({shift_q, carry[DIGITS]});
            work_d  = work_nxt;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(BIN_W - 1)) begin
               state_d = IDLE;
               busy_d  = 1'b0;
               valid_d = 1'b1;
               bcd_d   = work_nxt;
               ovf_d   = ovf_pend_q;
`ifdef BCD_RANGE_CHECK_EN
               range_err_d = range_pend_q;
               if (range_pend_q) begin
                  bcd_d = '0;
                  ovf_d = 1'b0;
               end
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: datapath flops are reset as well because bcd/ovf must read zero after reset.
      if (!rst_n) begin
         state_q    <= IDLE;
         shift_q    <= '0;
         work_q     <= '0;
         cnt_q      <= '0;
         busy_q     <= 1'b0;
         valid_q    <= 1'b0;
         bcd_q      <= '0;
         ovf_q      <= 1'b0;
         ovf_pend_q <= 1'b0;
`ifdef BCD_RANGE_CHECK_EN
         range_err_q  <= 1'b0;
         range_pend_q <= 1'b0;
`endif
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q    <= state_d;
         shift_q    <= shift_d;
         work_q     <= work_d;
         cnt_q      <= cnt_d;
         busy_q     <= busy_d;
         valid_q    <= valid_d;
         bcd_q      <= bcd_d;
         ovf_q      <= ovf_d;
         ovf_pend_q <= ovf_pend_d;
`ifdef BCD_RANGE_CHECK_EN
         range_err_q  <= range_err_d;
         range_pend_q <= range_pend_d;
`endif
      end
   end

   assign busy  = busy_q;
   assign valid = valid_q;
   assign bcd   = bcd_q;
   assign ovf   = ovf_q;
`ifdef BCD_RANGE_CHECK_EN
   assign range_err = range_err_q;
`else
   assign range_err = 1'b0;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed self-checking bench for bin2bcd_seq in three configurations.
module tb_bin2bcd_seq;

`ifdef BCD_RANGE_CHECK_EN
   localparam bit RCHK = 1'b1;
`else
   localparam bit RCHK = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        start_a = 1'b0;
   logic [5:0]  bin_a = '0;
   logic        busy_a, valid_a, ovf_a, rerr_a;
   logic [7:0]  bcd_a;

   logic        start_b = 1'b0;
   logic [9:0]  bin_b = '0;
   logic        busy_b, valid_b, ovf_b, rerr_b;
   logic [11:0] bcd_b;

   logic        start_c = 1'b0;
   logic [0:0]  bin_c = '0;
   logic        busy_c, valid_c, ovf_c, rerr_c;
   logic [3:0]  bcd_c;

   int n_cmp = 0;
   int n_bad = 0;

   bin2bcd_seq u_dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .bin(bin_a),
      .busy(busy_a), .valid(valid_a), .bcd(bcd_a), .ovf(ovf_a), .range_err(rerr_a)
   );

   bin2bcd_seq #(.BIN_W(10), .DIGITS(3), .MAX_VAL(1023)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .bin(bin_b),
      .busy(busy_b), .valid(valid_b), .bcd(bcd_b), .ovf(ovf_b), .range_err(rerr_b)
   );

   bin2bcd_seq #(.BIN_W(1), .DIGITS(1), .MAX_VAL(1)) u_dut_c (
      .clk(clk), .rst_n(rst_n), .start(start_c), .bin(bin_c),
      .busy(busy_c), .valid(valid_c), .bcd(bcd_c), .ovf(ovf_c), .range_err(rerr_c)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic vld(input int d);
      case (d)
         0:       return valid_a;
         1:       return valid_b;
         default: return valid_c;
      endcase
   endfunction

   function automatic logic bsy(input int d);
      case (d)
         0:       return busy_a;
         1:       return busy_b;
         default: return busy_c;
      endcase
   endfunction

   // One conversion: returns edges from acceptance to the valid cycle, and busy just after acceptance.
   task automatic go(input int d, input int v, output int lat, output logic busy1);
      @(negedge clk);
      case (d)
         0:       begin start_a = 1'b1; bin_a = 6'(v); end
         1:       begin start_b = 1'b1; bin_b = 10'(v); end
         default: begin start_c = 1'b1; bin_c = 1'(v); end
      endcase
      @(posedge clk);
      #1;
      start_a = 1'b0;
      start_b = 1'b0;
      start_c = 1'b0;
      lat   = 0;
      busy1 = 1'bx;
      forever begin
         @(negedge clk);
         if (lat == 0) busy1 = bsy(d);
         if (vld(d) === 1'b1) break;
         @(posedge clk);
         lat++;
         if (lat > 40) break;
      end
   endtask

   initial begin
      int   lat, m, nv;
      logic b1;
      logic [7:0] got;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_busy", busy_a, 1'b0);
      check("rst_valid", valid_a, 1'b0);
      check("rst_bcd", bcd_a, 8'h00);
      check("rst_ovf", ovf_a, 1'b0);
      check("rst_rerr", rerr_a, 1'b0);
      check("rst_bcd_b", bcd_b, 12'h000);
      rst_n = 1'b1;

      // 59: basic conversion, latency and pulse width
      go(0, 59, lat, b1);
      check("59_busy", b1, 1'b1);
      check("59_lat", lat, 6);
      check("59_bcd", bcd_a, 8'h59);
      check("59_ovf", ovf_a, 1'b0);
      @(negedge clk);
      check("59_pulse", valid_a, 1'b0);
      check("59_idle", busy_a, 1'b0);

      // Range boundary around MAX_VAL=60
      go(0, 63, lat, b1);
      check("63_bcd", bcd_a, RCHK ? 8'h00 : 8'h63);
      check("63_rerr", rerr_a, RCHK);
      check("63_ovf", ovf_a, 1'b0);
      go(0, 60, lat, b1);
      check("60_bcd", bcd_a, 8'h60);
      check("60_rerr", rerr_a, 1'b0);
      go(0, 61, lat, b1);
      check("61_bcd", bcd_a, RCHK ? 8'h00 : 8'h61);
      check("61_rerr", rerr_a, RCHK);

      // Start while busy is ignored
      @(negedge clk);
      start_a = 1'b1;
      bin_a   = 6'd45;
      @(posedge clk);
      #1 start_a = 1'b0;
      @(negedge clk);
      @(negedge clk);
      start_a = 1'b1;
      bin_a   = 6'd12;
      @(negedge clk);
      start_a = 1'b0;
      nv  = 0;
      got = 8'hxx;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (valid_a === 1'b1) begin
            nv++;
            got = bcd_a;
         end
      end
      check("busy_ign_count", nv, 1);
      check("busy_ign_bcd", got, 8'h45);
      check("hold_bcd", bcd_a, 8'h45);

      // Back-to-back: start held through the valid cycle
      @(negedge clk);
      start_a = 1'b1;
      bin_a   = 6'd45;
      @(posedge clk);
      #1 bin_a = 6'd12;
      lat = 0;
      forever begin
         @(negedge clk);
         if (valid_a === 1'b1) break;
         @(posedge clk);
         lat++;
         if (lat > 40) break;
      end
      check("b2b_lat1", lat, 6);
      check("b2b_bcd1", bcd_a, 8'h45);
      m = 0;
      forever begin
         @(posedge clk);
         m++;
         #1 if (m == 1) start_a = 1'b0;
         @(negedge clk);
         if (valid_a === 1'b1) break;
         if (m > 40) break;
      end
      check("b2b_gap", m, 7);
      check("b2b_bcd2", bcd_a, 8'h12);

      // Reset mid-conversion at cnt=3
      @(negedge clk);
      start_a = 1'b1;
      bin_a   = 6'd59;
      @(posedge clk);
      #1 start_a = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("mid_rst_busy", busy_a, 1'b0);
      check("mid_rst_bcd", bcd_a, 8'h00);
      check("mid_rst_valid", valid_a, 1'b0);
      nv = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (valid_a === 1'b1) nv++;
      end
      check("mid_rst_nopulse", nv, 0);
      go(0, 7, lat, b1);
      check("7_lat", lat, 6);
      check("7_bcd", bcd_a, 8'h07);

      // Zero input
      go(0, 0, lat, b1);
      check("0_lat", lat, 6);
      check("0_bcd", bcd_a, 8'h00);
      check("0_ovf", ovf_a, 1'b0);

      // BIN_W=10, DIGITS=3: top of range and overflow
      go(1, 999, lat, b1);
      check("999_lat", lat, 10);
      check("999_bcd", bcd_b, 12'h999);
      check("999_ovf", ovf_b, 1'b0);
      go(1, 1023, lat, b1);
      check("1023_bcd", bcd_b, 12'h023);
      check("1023_ovf", ovf_b, 1'b1);
      go(1, 100, lat, b1);
      check("100_bcd", bcd_b, 12'h100);
      check("100_ovf", ovf_b, 1'b0);

      // BIN_W=1, DIGITS=1
      go(2, 1, lat, b1);
      check("c1_lat", lat, 1);
      check("c1_bcd", bcd_c, 4'h1);
      check("c1_ovf", ovf_c, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
